// File: rtl/lb_arbiter.sv
// lb_arbiter: two-master round-robin arbiter onto one local-bus register slave.
// Optional slave response timeout enabled by defining LB_ARB_TIMEOUT_EN.
module lb_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int STRB_W         = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_waddr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic              m0_wen,
    output logic              m0_wready,
    input  logic [ADDR_W-1:0] m0_raddr,
    input  logic              m0_ren,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic [ADDR_W-1:0] m1_waddr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic              m1_wen,
    output logic              m1_wready,
    input  logic [ADDR_W-1:0] m1_raddr,
    input  logic              m1_ren,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] s_waddr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wen,
    input  logic              s_wready,
    output logic [ADDR_W-1:0] s_raddr,
    output logic              s_ren,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rvalid,
`ifdef LB_ARB_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t state, state_nx;
    logic   owner, last;
    logic   req0, req1, win;
    logic   own_wen, own_ren;
    logic   wack, rack, to;

`ifdef LB_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Self-complete only a request still held with no slave answer this cycle
    always_comb begin
        to = !rst && cnt == CW'(TIMEOUT_CYCLES - 1) &&
             ((state == WR && own_wen && !s_wready) || (state == RD && own_ren && !s_rvalid));
    end

    always_ff @(posedge clk) begin
        if (rst)
            timeout_err <= 1'b0;
        else if (to)
            timeout_err <= 1'b1;
    end
`else
    always_comb to = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        req0      = m0_wen | m0_ren;
        req1      = m1_wen | m1_ren;
        win       = (req0 && req1) ? ~last : req1;
        own_wen   = owner ? m1_wen : m0_wen;
        own_ren   = owner ? m1_ren : m0_ren;
        s_waddr   = owner ? m1_waddr : m0_waddr;
        s_wdata   = owner ? m1_wdata : m0_wdata;
        s_wstrb   = owner ? m1_wstrb : m0_wstrb;
        s_raddr   = owner ? m1_raddr : m0_raddr;
        s_wen     = !rst && state == WR && own_wen && !to;
        s_ren     = !rst && state == RD && own_ren && !to;
        wack      = (s_wen && s_wready) || (state == WR && to);
        rack      = (s_ren && s_rvalid) || (state == RD && to);
        m0_wready = wack && !owner;
        m1_wready = wack && owner;
        m0_rvalid = rack && !owner;
        m1_rvalid = rack && owner;
        m0_rdata  = to ? '1 : s_rdata;
        m1_rdata  = to ? '1 : s_rdata;
        busy      = !rst && state != IDLE;
    end

    // A dropped request ends the grant without any response
    always_comb begin
        state_nx = state;
        if (state == IDLE && (req0 || req1))
            state_nx = (win ? m1_wen : m0_wen) ? WR : RD;
        else if (state == WR && (!own_wen || wack))
            state_nx = IDLE;
        else if (state == RD && (!own_ren || rack))
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && (req0 || req1)) begin
                owner <= win;
                last  <= win;
            end
        end
    end
endmodule
